// File: rtl/pong_pkg.sv
// Shared definitions for the Pong ball engine: FSM state codes, mode encodings,
// screen geometry and a coordinate clamp helper.
package pong_pkg;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_SERVE     = 3'd1;
  localparam logic [2:0] ST_FLY       = 3'd2;
  localparam logic [2:0] ST_MISS      = 3'd3;
  localparam logic [2:0] ST_SCORE     = 3'd4;
  localparam logic [2:0] ST_GAME_OVER = 3'd5;

  typedef enum logic [2:0] {
    IDLE      = ST_IDLE,
    SERVE     = ST_SERVE,
    FLY       = ST_FLY,
    MISS      = ST_MISS,
    SCORE     = ST_SCORE,
    GAME_OVER = ST_GAME_OVER
  } state_e;

  localparam logic [1:0] MODE_IDLE   = 2'd0;
  localparam logic [1:0] MODE_SINGLE = 2'd1;
  localparam logic [1:0] MODE_MULTI  = 2'd2;

  localparam logic [10:0] CENTRE_X   = 11'd504;
  localparam logic [10:0] CENTRE_Y   = 11'd376;
  localparam int          SCREEN_MAX = 1023;

  function automatic logic [10:0] clamp_coord(input logic signed [11:0] v);
    if (v < 12'sd0) return 11'd0;
    if (v > $signed(12'(SCREEN_MAX))) return 11'(SCREEN_MAX);
    return v[10:0];
  endfunction

endpackage

// File: rtl/pong_ball_engine_if.sv
// Frame-rate inputs from the player logic and registered ball/score outputs
// toward the draw pipeline. end_of_frame is a one-cycle strobe with no back-pressure.
interface pong_ball_engine_if #(parameter int POINT_W = 4);
  import pong_pkg::*;

  logic               end_of_frame;
  logic               serve;
  logic [1:0]         mode;
  logic [9:0]         pos_of_player_1;
  logic [9:0]         pos_of_player_2;
  logic [10:0]        x_pos_of_ball;
  logic [10:0]        y_pos_of_ball;
  logic [POINT_W-1:0] points_player_1;
  logic [POINT_W-1:0] points_player_2;
  logic               racket_hit;
  logic               game_over;
  logic               winner;
  state_e             state_dbg;

  modport master (
    output end_of_frame, serve, mode, pos_of_player_1, pos_of_player_2,
    input  x_pos_of_ball, y_pos_of_ball, points_player_1, points_player_2,
           racket_hit, game_over, winner, state_dbg
  );

  modport slave (
    input  end_of_frame, serve, mode, pos_of_player_1, pos_of_player_2,
    output x_pos_of_ball, y_pos_of_ball, points_player_1, points_player_2,
           racket_hit, game_over, winner, state_dbg
  );

endinterface

// File: rtl/ball_hit_zone.sv
// Racket overlap test and deflection: splits the racket into five zones and
// maps the zone to a signed vertical velocity (centre zone = 0).
module ball_hit_zone #(
  parameter int BALL_SIZE = 15,
  parameter int RACKET_H  = 80,
  parameter int VY_STEP   = 2
) (
  input  logic [10:0]       ball_y,
  input  logic [9:0]        racket_top,
  output logic              hit,
  output logic signed [7:0] vy_zone
);

  logic signed [12:0] d_s;
  logic [12:0]        d_cl;
  logic [2:0]         zone;
  logic signed [7:0]  zs;

  always_comb begin
    hit = (({1'b0, ball_y} + 12'(BALL_SIZE)) >= {2'b0, racket_top}) &&
          ({1'b0, ball_y} <= ({2'b0, racket_top} + 12'(RACKET_H)));
    // Offset of the ball centre below the racket top, limited to the racket span
    d_s = $signed({2'b0, ball_y}) + $signed(13'(BALL_SIZE / 2)) - $signed({3'b0, racket_top});
    if (d_s < 13'sd0)                           d_cl = '0;
    else if (d_s > $signed(13'(RACKET_H - 1)))  d_cl = 13'(RACKET_H - 1);
    else                                        d_cl = d_s;
    zone    = 3'((32'(d_cl) * 32'd5) / 32'(RACKET_H));
    zs      = $signed({5'b0, zone}) - 8'sd2;
    vy_zone = zs * $signed(8'(VY_STEP));
  end

endmodule

// File: rtl/pong_ball_engine.sv
// Pong ball motion and scoring FSM, advancing once per end_of_frame tick.
// Define BALL_SPEEDUP_EN to speed the ball up by one pixel/frame per racket hit.
module pong_ball_engine
  import pong_pkg::*;
#(
  parameter int TOP_WALL    = 51,
  parameter int BOTTOM_WALL = 717,
  parameter int P2_X        = 100,
  parameter int P1_X        = 923,
  parameter int BALL_SIZE   = 15,
  parameter int RACKET_H    = 80,
  parameter int VX_INIT     = 5,
  parameter int VX_MAX      = 9,
  parameter int VY_STEP     = 2,
  parameter int WIN_SCORE   = 9,
  parameter int POINT_W     = 4
) (
  input logic              clk65MHz,
  input logic              rst,
  pong_ball_engine_if.slave bus
);

  localparam logic signed [11:0] S_TOP = 12'(TOP_WALL);
  localparam logic signed [11:0] S_BOT = 12'(BOTTOM_WALL);
  localparam logic signed [11:0] S_P1  = 12'(P1_X);
  localparam logic signed [11:0] S_P2  = 12'(P2_X);
  localparam logic signed [11:0] S_BS  = 12'(BALL_SIZE);
  localparam logic signed [11:0] S_MAX = 12'(SCREEN_MAX);
  localparam logic [10:0] X_R_HIT = 11'(P1_X - BALL_SIZE);
  localparam logic [10:0] X_L_HIT = 11'(P2_X);
  localparam logic [10:0] X_R_OUT = 11'(SCREEN_MAX - BALL_SIZE);
  localparam logic [10:0] Y_TOP   = 11'(TOP_WALL);
  localparam logic [10:0] Y_BOT   = 11'(BOTTOM_WALL);
  localparam logic signed [7:0] VX_I   = 8'(VX_INIT);
  // Never below the serve speed, so the ceiling cannot slow a fresh serve
  localparam logic signed [7:0] VX_CAP = 8'((VX_MAX > VX_INIT) ? VX_MAX : VX_INIT);
  localparam logic [POINT_W-1:0] WIN = POINT_W'(WIN_SCORE);

  logic [2:0]         state_r, state_n;
  logic [10:0]        x_r, x_n, y_r, y_n;
  logic signed [7:0]  vx_r, vx_n, vy_r, vy_n;
  logic [POINT_W-1:0] p1_r, p1_n, p2_r, p2_n;
  logic               hit_r, hit_n, go_r, go_n, win_r, win_n;

  logic signed [11:0] nx, ny;
  logic signed [7:0]  vx_abs, hit_mag, vy_base, vy_abs, vy_z1, vy_z2;
  logic               hit1, hit2, mode_active, tick;

  ball_hit_zone #(.BALL_SIZE(BALL_SIZE), .RACKET_H(RACKET_H), .VY_STEP(VY_STEP)) u_zone_p1 (
    .ball_y(y_r), .racket_top(bus.pos_of_player_1), .hit(hit1), .vy_zone(vy_z1)
  );

  ball_hit_zone #(.BALL_SIZE(BALL_SIZE), .RACKET_H(RACKET_H), .VY_STEP(VY_STEP)) u_zone_p2 (
    .ball_y(y_r), .racket_top(bus.pos_of_player_2), .hit(hit2), .vy_zone(vy_z2)
  );

  assign tick        = bus.end_of_frame;
  assign mode_active = (bus.mode == MODE_SINGLE) || (bus.mode == MODE_MULTI);

  always_comb begin
    nx     = $signed({1'b0, x_r}) + $signed({{4{vx_r[7]}}, vx_r});
    ny     = $signed({1'b0, y_r}) + $signed({{4{vy_r[7]}}, vy_r});
    vx_abs = vx_r[7] ? -vx_r : vx_r;
`ifdef BALL_SPEEDUP_EN
    hit_mag = (vx_abs >= VX_CAP) ? VX_CAP : vx_abs + 8'sd1;
`else
    hit_mag = (vx_abs > VX_CAP) ? VX_CAP : vx_abs;
`endif
    state_n = state_r; x_n = x_r; y_n = y_r; vx_n = vx_r; vy_n = vy_r;
    p1_n = p1_r; p2_n = p2_r; hit_n = 1'b0; go_n = go_r; win_n = win_r;
    vy_base = vy_r;
    vy_abs  = vy_r;

    case (state_r)
      ST_IDLE: begin
        x_n = CENTRE_X; y_n = CENTRE_Y;
        if (mode_active) state_n = ST_SERVE;
      end
      ST_SERVE: begin
        x_n = CENTRE_X; y_n = CENTRE_Y;
        if (tick && bus.serve) state_n = ST_FLY;
      end
      ST_FLY, ST_MISS: if (tick) begin
        x_n = clamp_coord(nx);
        if (state_r == ST_FLY) begin
          if (!vx_r[7] && (vx_r != 8'sd0) && ((nx + S_BS) >= S_P1)) begin
            if (hit1) begin
              x_n = X_R_HIT; vx_n = -hit_mag; vy_base = vy_z1; hit_n = 1'b1;
            end else begin
              state_n = ST_MISS;
            end
          end else if (vx_r[7] && (nx <= S_P2)) begin
            if (bus.mode == MODE_MULTI) begin
              if (hit2) begin
                x_n = X_L_HIT; vx_n = hit_mag; vy_base = vy_z2; hit_n = 1'b1;
              end else begin
                state_n = ST_MISS;
              end
            end else begin
              // Single player: the left plane is a plain wall
              x_n = X_L_HIT; vx_n = vx_abs;
            end
          end
        end else if (nx < 12'sd0) begin
          x_n = '0; state_n = ST_SCORE;
          if (p1_r != WIN) p1_n = p1_r + POINT_W'(1);
        end else if ((nx + S_BS) > S_MAX) begin
          x_n = X_R_OUT; state_n = ST_SCORE;
          if (p2_r != WIN) p2_n = p2_r + POINT_W'(1);
        end
        vy_abs = vy_base[7] ? -vy_base : vy_base;
        vy_n   = vy_base;
        if (ny <= S_TOP) begin
          y_n = Y_TOP; vy_n = vy_abs;
        end else if (ny >= S_BOT) begin
          y_n = Y_BOT; vy_n = -vy_abs;
        end else begin
          y_n = ny[10:0];
        end
      end
      ST_SCORE: begin
        // vx still points at the side the ball left through, i.e. the conceding player
        x_n = CENTRE_X; y_n = CENTRE_Y; vy_n = '0;
        vx_n = vx_r[7] ? -VX_I : VX_I;
        if (p1_r == WIN) begin
          state_n = ST_GAME_OVER; go_n = 1'b1; win_n = 1'b0;
        end else if (p2_r == WIN) begin
          state_n = ST_GAME_OVER; go_n = 1'b1; win_n = 1'b1;
        end else begin
          state_n = ST_SERVE;
        end
      end
      ST_GAME_OVER: begin
        x_n = CENTRE_X; y_n = CENTRE_Y;
        if (tick && bus.serve) begin
          state_n = ST_SERVE; p1_n = '0; p2_n = '0; go_n = 1'b0; win_n = 1'b0;
          vx_n = VX_I; vy_n = '0;
        end
      end
      default: state_n = ST_IDLE;
    endcase

    if (!mode_active) begin
      state_n = ST_IDLE; x_n = CENTRE_X; y_n = CENTRE_Y; vx_n = VX_I; vy_n = '0;
      p1_n = '0; p2_n = '0; hit_n = 1'b0; go_n = 1'b0; win_n = 1'b0;
    end
  end

  always_ff @(posedge clk65MHz) begin
    if (rst) begin
      state_r <= ST_IDLE;  x_r <= CENTRE_X; y_r <= CENTRE_Y;
      vx_r <= VX_I;        vy_r <= '0;
      p1_r <= '0;          p2_r <= '0;
      hit_r <= 1'b0;       go_r <= 1'b0;    win_r <= 1'b0;
    end else begin
      state_r <= state_n;  x_r <= x_n;      y_r <= y_n;
      vx_r <= vx_n;        vy_r <= vy_n;
      p1_r <= p1_n;        p2_r <= p2_n;
      hit_r <= hit_n;      go_r <= go_n;    win_r <= win_n;
    end
  end

  assign bus.x_pos_of_ball   = x_r;
  assign bus.y_pos_of_ball   = y_r;
  assign bus.points_player_1 = p1_r;
  assign bus.points_player_2 = p2_r;
  assign bus.racket_hit      = hit_r;
  assign bus.game_over       = go_r;
  assign bus.winner          = win_r;
  assign bus.state_dbg       = state_e'(state_r);

endmodule

// File: tb/tb_pong_ball_engine.sv
// Directed bench for pong_ball_engine (default build): serve, racket hit/miss,
// wall bounce, scoring to game over, restart and mode abort.
module tb_pong_ball_engine;
  import pong_pkg::*;

  logic clk65MHz = 1'b0;
  logic rst      = 1'b1;
  int   n_checks = 0;
  int   n_pass   = 0;
  logic [31:0] exp_q[$];

  pong_ball_engine_if #(.POINT_W(4)) bus ();

  pong_ball_engine dut (
    .clk65MHz (clk65MHz),
    .rst      (rst),
    .bus      (bus)
  );

  // Clock and watchdog
  always #8 clk65MHz = ~clk65MHz;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "bench timeout");
  end

  // Driver tasks
  task automatic tick();
    @(negedge clk65MHz);
    bus.end_of_frame = 1'b1;
    @(negedge clk65MHz);
    bus.end_of_frame = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic serve_tick();
    bus.serve = 1'b1;
    tick();
    bus.serve = 1'b0;
  endtask

  // Scoreboard check
  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  task automatic check_ball(input string tag, input int ex, input int ey);
    check_val({tag, "_x"}, 32'(bus.x_pos_of_ball), 32'(ex));
    check_val({tag, "_y"}, 32'(bus.y_pos_of_ball), 32'(ey));
  endtask

  initial begin
    bus.end_of_frame    = 1'b0;
    bus.serve           = 1'b0;
    bus.mode            = MODE_IDLE;
    bus.pos_of_player_1 = 10'd336;
    bus.pos_of_player_2 = 10'd0;
    repeat (3) @(negedge clk65MHz);
    rst = 1'b0;

    // Reset state
    check_val("rst_state", 32'(bus.state_dbg), 32'(ST_IDLE));
    check_ball("rst", 504, 376);
    check_val("rst_p1", 32'(bus.points_player_1), 0);
    check_val("rst_p2", 32'(bus.points_player_2), 0);
    check_val("rst_hit", 32'(bus.racket_hit), 0);
    check_val("rst_go", 32'(bus.game_over), 0);
    check_val("rst_win", 32'(bus.winner), 0);

    // Serve and fly right
    bus.mode = MODE_MULTI;
    @(negedge clk65MHz);
    check_val("idle_to_serve", 32'(bus.state_dbg), 32'(ST_SERVE));
    serve_tick();
    check_val("serve_to_fly", 32'(bus.state_dbg), 32'(ST_FLY));
    check_ball("serve_hold", 504, 376);
    ticks(10);
    check_ball("fly10", 554, 376);
    check_val("fly10_hit", 32'(bus.racket_hit), 0);

    // Centre-zone hit on the right racket
    ticks(71);
    exp_q.push_back(1);
    exp_q.push_back(0);
    check_ball("rhit", 908, 376);
    check_val("rhit_pulse", 32'(bus.racket_hit), exp_q.pop_front());
    @(negedge clk65MHz);
    check_val("rhit_pulse_end", 32'(bus.racket_hit), exp_q.pop_front());
    tick();
    check_ball("after_rhit", 903, 376);

    // Left miss, ball runs out, player 1 scores, serve toward player 2
    ticks(161);
    check_val("lmiss_state", 32'(bus.state_dbg), 32'(ST_MISS));
    check_ball("lmiss", 98, 376);
    ticks(20);
    check_val("lexit_state", 32'(bus.state_dbg), 32'(ST_SCORE));
    check_val("lexit_x", 32'(bus.x_pos_of_ball), 0);
    check_val("lexit_p1", 32'(bus.points_player_1), 1);
    @(negedge clk65MHz);
    check_val("lexit_serve", 32'(bus.state_dbg), 32'(ST_SERVE));
    check_ball("lexit_centre", 504, 376);

    // Player 1 scores up to 8 with serves heading left
    for (int p = 0; p < 7; p++) begin
      serve_tick();
      ticks(101);
      @(negedge clk65MHz);
    end
    check_val("p1_eight", 32'(bus.points_player_1), 8);
    check_val("p1_eight_state", 32'(bus.state_dbg), 32'(ST_SERVE));

    // Winning point
    serve_tick();
    ticks(101);
    check_val("win_score_state", 32'(bus.state_dbg), 32'(ST_SCORE));
    check_val("win_p1", 32'(bus.points_player_1), 9);
    @(negedge clk65MHz);
    check_val("go_state", 32'(bus.state_dbg), 32'(ST_GAME_OVER));
    check_val("go_flag", 32'(bus.game_over), 1);
    check_val("go_winner", 32'(bus.winner), 0);
    check_ball("go_centre", 504, 376);
    tick();
    check_val("go_frozen_p1", 32'(bus.points_player_1), 9);
    check_val("go_hold", 32'(bus.state_dbg), 32'(ST_GAME_OVER));
    serve_tick();
    check_val("restart_state", 32'(bus.state_dbg), 32'(ST_SERVE));
    check_val("restart_p1", 32'(bus.points_player_1), 0);
    check_val("restart_go", 32'(bus.game_over), 0);

    // Right miss: player 2 scores, serve back toward player 1
    bus.pos_of_player_1 = 10'd600;
    serve_tick();
    ticks(81);
    check_val("rmiss_state", 32'(bus.state_dbg), 32'(ST_MISS));
    check_val("rmiss_x", 32'(bus.x_pos_of_ball), 909);
    ticks(20);
    check_val("rexit_state", 32'(bus.state_dbg), 32'(ST_SCORE));
    check_val("rexit_x", 32'(bus.x_pos_of_ball), 1008);
    check_val("rexit_p2", 32'(bus.points_player_2), 1);
    @(negedge clk65MHz);
    check_ball("rexit_centre", 504, 376);
    serve_tick();
    tick();
    check_val("reserve_vx", 32'(bus.x_pos_of_ball), 509);

    // Zone-0 hit gives vy=-4, then top wall bounce
    bus.pos_of_player_1 = 10'd380;
    ticks(80);
    check_ball("zone0_hit", 908, 376);
    check_val("zone0_pulse", 32'(bus.racket_hit), 1);
    ticks(81);
    check_ball("climb", 503, 52);
    tick();
    check_val("top_clamp", 32'(bus.y_pos_of_ball), 51);
    tick();
    check_val("top_bounce", 32'(bus.y_pos_of_ball), 55);

    // Mode abort mid-flight
    @(negedge clk65MHz);
    bus.mode = MODE_IDLE;
    @(negedge clk65MHz);
    check_val("abort_state", 32'(bus.state_dbg), 32'(ST_IDLE));
    check_ball("abort", 504, 376);
    check_val("abort_p2", 32'(bus.points_player_2), 0);
    check_val("abort_p1", 32'(bus.points_player_1), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
